// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared ALU op encoding, issue states and datapath widths
package alu_issue_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int SHAMT_W = 5;

  // Encodings 7..15 are unassigned; the alu returns 0 for them.
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    LSL = 4'd5,
    LSR = 4'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } issue_state_t;

  // Logical shifts only look at the low SHAMT_W bits of operand2.
  function automatic logic is_shift(alu_op_t op);
    return (op == LSL) || (op == LSR);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - NREGS x 32 register file, two read ports, debug port, one write port
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;

  // x0 and addresses beyond the implemented file are never stored
  function automatic logic addr_ok(logic [REG_AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  // Combinational read ports; x0 and out-of-range addresses read as zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    if (addr_ok(rs1_addr)) rs1_data = regs_q[rs1_addr[AW-1:0]];
    if (addr_ok(rs2_addr)) rs2_data = regs_q[rs2_addr[AW-1:0]];
    if (addr_ok(dbg_addr)) dbg_data = regs_q[dbg_addr[AW-1:0]];
  end

  // Next register contents: single write port with x0 suppression
  always_comb begin
    regs_d = regs_q;
    if (wr_en && addr_ok(wr_addr)) regs_d[wr_addr[AW-1:0]] = wr_data;
  end

  // Storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage sequencer feeding the alu and writing its result back
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [XLEN-1:0]   in_imm,
  output logic              alu_ce,
  output alu_op_t           alu_op_sel,
  output logic [XLEN-1:0]   alu_operand1,
  output logic [XLEN-1:0]   alu_operand2,
  input  logic [XLEN-1:0]   alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  issue_state_t      state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   opnd1_q, opnd1_d;
  logic [XLEN-1:0]   opnd2_q, opnd2_d;

  logic              accept;
  logic [XLEN-1:0]   rf_rs1_data;
  logic [XLEN-1:0]   rf_rs2_data;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic              fwd_en;

  alu_issue_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs1_addr(in_rs1),
    .rs1_data(rf_rs1_data),
    .rs2_addr(in_rs2),
    .rs2_data(rf_rs2_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .wr_en   (wb_valid),
    .wr_addr (rd_q),
    .wr_data (alu_result)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE or WB, ISSUE always drains into WB
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the alu only clocks during ISSUE so its result holds through WB
  always_comb begin
    in_ready     = (state_q == IDLE) || (state_q == WB);
    alu_ce       = (state_q == ISSUE);
    wb_valid     = (state_q == WB);
    wb_rd        = wb_valid ? rd_q : '0;
    wb_data      = alu_result;
    alu_op_sel   = op_q;
    alu_operand1 = opnd1_q;
    alu_operand2 = is_shift(op_q) ? {{(XLEN-SHAMT_W){1'b0}}, opnd2_q[SHAMT_W-1:0]} : opnd2_q;
  end

  // Operand capture, bypassing the retiring result when a source matches it
  always_comb begin
    accept  = in_valid && in_ready;
    fwd_en  = wb_valid && (rd_q != '0);
    src1    = (fwd_en && (in_rs1 == rd_q)) ? alu_result : rf_rs1_data;
    src2    = (fwd_en && (in_rs2 == rd_q)) ? alu_result : rf_rs2_data;
    op_d    = op_q;
    rd_d    = rd_q;
    opnd1_d = opnd1_q;
    opnd2_d = opnd2_q;
    if (accept) begin
      op_d    = in_op;
      rd_d    = in_rd;
      opnd1_d = src1;
      opnd2_d = in_use_imm ? in_imm : src2;
    end
  end

  // Captured instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= ADD;
      rd_q    <= '0;
      opnd1_q <= '0;
      opnd2_q <= '0;
    end else begin
      op_q    <= op_d;
      rd_q    <= rd_d;
      opnd1_q <= opnd1_d;
      opnd2_q <= opnd2_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with alu model and architectural reference
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        alu_ce;
  alu_op_t     alu_op_sel;
  logic [31:0] alu_operand1, alu_operand2;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_regs [32];

  alu_issue #(.NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_ce(alu_ce), .alu_op_sel(alu_op_sel),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream alu: shifts use the whole operand2, so an unmasked amount shows up in the result
  function automatic logic [31:0] hw_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      LSL:     return (b > 32'd31) ? 32'd0 : (a << b);
      LSR:     return (b > 32'd31) ? 32'd0 : (a >> b);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst)         alu_result <= 32'd0;
    else if (alu_ce) alu_result <= hw_alu(alu_op_sel, alu_operand1, alu_operand2);
  end

  // Architectural meaning of one instruction
  function automatic logic [31:0] arch_result(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      LSL:     return a << sh;
      LSR:     return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  // Present one instruction, wait (bounded) for acceptance, update the sequential model
  task automatic send(input alu_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic use_imm, input logic [31:0] imm);
    int guard;
    logic [31:0] a, b, r;
    exp_t e;
    guard = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm;
    while (!in_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
      in_valid = 1'b0;
      return;
    end
    a = ref_regs[rs1];
    b = use_imm ? imm : ref_regs[rs2];
    r = arch_result(op, a, b);
    if (rd != 5'd0) ref_regs[rd] = r;
    e.cyc = cyc + 2; e.rd = rd; e.data = r;
    exp_q.push_back(e);
    last_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Every retirement must match the model, in order, exactly two cycles after accept
  task automatic wb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: rd=%0d data=%h at cycle %0d, expected no retirement", wb_rd, wb_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.rd !== wb_rd || e.data !== wb_data) begin
            errors++;
            $display("FAIL wb_retire: got cyc=%0d rd=%0d data=%h, expected cyc=%0d rd=%0d data=%h",
                     cyc, wb_rd, wb_data, e.cyc, e.rd, e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_missing: no wb_valid at cycle %0d, expected rd=%0d data=%h", cyc, exp_q[0].rd, exp_q[0].data);
        e = exp_q.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (alu_ce !== 1'b0) begin errors++; $display("FAIL reset_alu_ce: got %b expected 0", alu_ce); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); end
    checks++; if (alu_op_sel !== ADD) begin errors++; $display("FAIL reset_op_sel: got %0d expected %0d", alu_op_sel, ADD); end
    checks++; if (alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", alu_operand1, alu_operand2); end
    checks++; if (wb_data !== alu_result) begin errors++; $display("FAIL reset_wb_data: got %h expected %h", wb_data, alu_result); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg x%0d: got %h expected 0", i, dbg_data); end
    end
  endtask

  task automatic test_addi();
    do_reset();
    send(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5);
    checks++; if (alu_ce !== 1'b1) begin errors++; $display("FAIL addi_ce: got %b expected 1", alu_ce); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL addi_early_wb: got %b expected 0", wb_valid); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd5) begin errors++; $display("FAIL addi_wb: got v=%b rd=%0d data=%h expected 1/1/5", wb_valid, wb_rd, wb_data); end
    @(posedge clk); #1;
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL addi_dbg: got %h expected 5", dbg_data); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL addi_wb_pulse: got %b expected 0", wb_valid); end
  endtask

  task automatic test_forward();
    int acc1;
    do_reset();
    send(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5);
    acc1 = last_acc;
    send(ADD, 5'd2, 5'd1, 5'd1, 1'b0, 32'd0);
    checks++; if (last_acc - acc1 != 2) begin errors++; $display("FAIL fwd_spacing: got %0d cycles expected 2", last_acc - acc1); end
    checks++; if (alu_operand1 !== 32'd5 || alu_operand2 !== 32'd5) begin errors++; $display("FAIL fwd_operands: got %h/%h expected 5/5", alu_operand1, alu_operand2); end
    @(posedge clk); #1;
    checks++; if (wb_rd !== 5'd2 || wb_data !== 32'd10) begin errors++; $display("FAIL fwd_wb: got rd=%0d data=%h expected 2/a", wb_rd, wb_data); end
  endtask

  task automatic test_x0();
    do_reset();
    send(ADD, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7);
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd7) begin errors++; $display("FAIL x0_wb: got v=%b rd=%0d data=%h expected 1/0/7", wb_valid, wb_rd, wb_data); end
    send(ADD, 5'd3, 5'd0, 5'd0, 1'b0, 32'd0);
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL x0_dbg: got %h expected 0", dbg_data); end
    checks++; if (alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0) begin errors++; $display("FAIL x0_nofwd: got %h/%h expected 0/0", alu_operand1, alu_operand2); end
    @(posedge clk); #1;
    checks++; if (wb_rd !== 5'd3 || wb_data !== 32'd0) begin errors++; $display("FAIL x0_read_wb: got rd=%0d data=%h expected 3/0", wb_rd, wb_data); end
  endtask

  task automatic test_shift();
    do_reset();
    send(ADD, 5'd4, 5'd0, 5'd0, 1'b1, 32'd1);
    send(LSL, 5'd5, 5'd4, 5'd0, 1'b1, 32'd33);
    checks++; if (alu_ce !== 1'b1 || alu_operand2 !== 32'd1) begin errors++; $display("FAIL shift_mask: got ce=%b op2=%h expected 1/1", alu_ce, alu_operand2); end
    @(posedge clk); #1;
    checks++; if (wb_rd !== 5'd5 || wb_data !== 32'd2) begin errors++; $display("FAIL shift_wb: got rd=%0d data=%h expected 5/2", wb_rd, wb_data); end
    send(SUB, 5'd6, 5'd4, 5'd0, 1'b1, 32'd2);
    checks++; if (alu_operand2 !== 32'd2) begin errors++; $display("FAIL sub_op2: got %h expected 2", alu_operand2); end
    @(posedge clk); #1;
    checks++; if (wb_rd !== 5'd6 || wb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wb: got rd=%0d data=%h expected 6/ffffffff", wb_rd, wb_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(ADD, 5'd7, 5'd0, 5'd0, 1'b1, 32'd9);
    checks++; if (alu_ce !== 1'b1) begin errors++; $display("FAIL mid_issue: got ce=%b expected 1", alu_ce); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || alu_ce !== 1'b0) begin errors++; $display("FAIL mid_abort: got v=%b rdy=%b ce=%b expected 0/1/0", wb_valid, in_ready, alu_ce); end
    dbg_addr = 5'd7; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL mid_dbg: got %h expected 0", dbg_data); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = ADD; in_rd = 5'd8; in_rs1 = 5'd0; in_use_imm = 1'b1; in_imm = 32'd3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (alu_ce !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_priority: got ce=%b rdy=%b expected 0/1", alu_ce, in_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send(alu_op_t'(4'($urandom_range(0, 9))), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d retirements outstanding, expected 0", exp_q.size()); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_data !== ref_regs[i]) begin errors++; $display("FAIL rand_regs x%0d: got %h expected %h", i, dbg_data, ref_regs[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = ADD; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
    fork
      wb_monitor();
    join_none
    test_reset();
    test_addi();
    test_forward();
    test_x0();
    test_shift();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
